// File: rtl/sat_accum_bank_if.sv
// Request/result bundle for the saturating accumulator bank.
// The master side issues requests and accepts results; the slave side is the bank.
interface sat_accum_bank_if #(
  parameter int WIDTH = 14,
  parameter int CH_W  = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_delta;
  logic                    in_sub;
  logic                    in_clr;

  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [WIDTH-1:0] out_value;
  logic                    out_sat;
  logic                    out_err;

  modport master (
    output in_valid, in_ch, in_delta, in_sub, in_clr, out_ready,
    input  in_ready, out_valid, out_ch, out_value, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_ch, in_delta, in_sub, in_clr, out_ready,
    output in_ready, out_valid, out_ch, out_value, out_sat, out_err
  );
endinterface

// File: rtl/sat_accum_bank.sv
// Multi-channel signed accumulator bank with programmable clamp window and sticky saturation flags.
// One-cycle latency through a single output register; in_ready drops while a result is stalled.
module sat_accum_bank #(
  parameter int WIDTH    = 14,
  parameter int CHANNELS = 8,
  parameter int CH_W     = 3,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sat_accum_bank_if.slave         bus,
  input  logic signed [WIDTH-1:0] lim_hi,
  input  logic signed [WIDTH-1:0] lim_lo,
  input  logic                    flag_clr,
  output logic [CHANNELS-1:0]     sat_flags,
  output logic [CNT_W-1:0]        sat_count
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic signed [WIDTH-1:0] acc [CHANNELS];

  logic                    accept;
  logic                    ch_ok;
  logic                    sat;
  logic                    sat_evt;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] res;
  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   d_ext;
  logic signed [WIDTH:0]   hi_ext;
  logic signed [WIDTH:0]   lo_ext;
  logic signed [WIDTH:0]   r;
  logic [CHANNELS-1:0]     flags_nxt;
  logic [CNT_W-1:0]        cnt_nxt;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign ch_ok        = {1'b0, bus.in_ch} < CH_LIMIT;
  assign sat_evt      = accept && ch_ok && sat;

  always_comb begin
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.in_ch == CH_W'(i)) cur = acc[i];
    end

    // One extra bit of headroom makes the sum exact, so the clamp sees the true value.
    a_ext  = {cur[WIDTH-1], cur};
    d_ext  = {bus.in_delta[WIDTH-1], bus.in_delta};
    hi_ext = {lim_hi[WIDTH-1], lim_hi};
    lo_ext = {lim_lo[WIDTH-1], lim_lo};

    if (bus.in_clr)      r = '0;
    else if (bus.in_sub) r = a_ext - d_ext;
    else                 r = a_ext + d_ext;

    // Upper bound wins, so an inverted window still resolves deterministically.
    if (r > hi_ext) begin
      res = lim_hi;
      sat = 1'b1;
    end else if (r < lo_ext) begin
      res = lim_lo;
      sat = 1'b1;
    end else begin
      res = r[WIDTH-1:0];
      sat = 1'b0;
    end
  end

  // A clear in the same cycle as an event lands first, so the event survives.
  always_comb begin
    flags_nxt = flag_clr ? '0 : sat_flags;
    cnt_nxt   = flag_clr ? '0 : sat_count;
    if (sat_evt) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.in_ch == CH_W'(i)) flags_nxt[i] = 1'b1;
      end
      if (cnt_nxt != '1) cnt_nxt = cnt_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (accept && ch_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.in_ch == CH_W'(i)) acc[i] <= res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flags <= '0;
      sat_count <= '0;
    end else begin
      sat_flags <= flags_nxt;
      sat_count <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_value <= '0;
      bus.out_sat   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_ch    <= bus.in_ch;
      bus.out_value <= ch_ok ? res : '0;
      bus.out_sat   <= ch_ok && sat;
      bus.out_err   <= !ch_ok;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_accum_bank.sv
// Directed bench for sat_accum_bank: arithmetic, clamping, flags, backpressure and reset.
module tb_sat_accum_bank;
  localparam int WIDTH    = 14;
  localparam int CHANNELS = 8;
  localparam int CH_W     = 4;
  localparam int CNT_W    = 16;
  localparam int MAXV     = 8191;
  localparam int MINV     = -8192;

  logic                    clk;
  logic                    rst_n;
  logic signed [WIDTH-1:0] lim_hi;
  logic signed [WIDTH-1:0] lim_lo;
  logic                    flag_clr;
  logic [CHANNELS-1:0]     sat_flags;
  logic [CNT_W-1:0]        sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  sat_accum_bank_if #(.WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  sat_accum_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .lim_hi    (lim_hi),
    .lim_lo    (lim_lo),
    .flag_clr  (flag_clr),
    .sat_flags (sat_flags),
    .sat_count (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one request at a negedge, waits (bounded) for acceptance, returns 1ns after the accept edge.
  task automatic xact(input int ch, input int delta, input logic sub, input logic clr, input logic fclr);
    int waits;
    waits = 0;
    @(negedge clk);
    bus.in_ch    = CH_W'(ch);
    bus.in_delta = WIDTH'(delta);
    bus.in_sub   = sub;
    bus.in_clr   = clr;
    flag_clr     = fclr;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flag_clr     = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int ch, input int value, input int sat);
    chk({tag, "_vld"}, int'(bus.out_valid), 1);
    chk({tag, "_ch"},  int'(bus.out_ch), ch);
    chk({tag, "_val"}, int'(bus.out_value), value);
    chk({tag, "_sat"}, int'(bus.out_sat), sat);
    chk({tag, "_err"}, int'(bus.out_err), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.in_delta = '0;
    bus.in_sub   = 1'b0;
    bus.in_clr   = 1'b0;
    bus.out_ready = 1'b1;
    flag_clr     = 1'b0;
    lim_hi       = WIDTH'(MAXV);
    lim_lo       = WIDTH'(MINV);

    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_ch",    int'(bus.out_ch), 0);
    chk("rst_out_value", int'(bus.out_value), 0);
    chk("rst_out_sat",   int'(bus.out_sat), 0);
    chk("rst_out_err",   int'(bus.out_err), 0);
    chk("rst_flags",     int'(sat_flags), 0);
    chk("rst_count",     int'(sat_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, neighbours untouched.
    xact(3, 100, 1'b0, 1'b0, 1'b0);
    expect_out("add3", 3, 100, 0);
    xact(0, 0, 1'b0, 1'b0, 1'b0);
    expect_out("ch0_zero", 0, 0, 0);
    xact(7, 0, 1'b0, 1'b0, 1'b0);
    expect_out("ch7_zero", 7, 0, 0);

    // Full-range signed saturation both ways.
    xact(0, 8000, 1'b0, 1'b0, 1'b0);
    expect_out("ch0_8000", 0, 8000, 0);
    xact(0, 500, 1'b0, 1'b0, 1'b0);
    expect_out("pos_sat", 0, MAXV, 1);
    chk("pos_sat_flags", int'(sat_flags), 1);
    chk("pos_sat_count", int'(sat_count), 1);
    xact(0, 0, 1'b0, 1'b1, 1'b0);
    expect_out("ch0_clr", 0, 0, 0);
    xact(0, 8000, 1'b1, 1'b0, 1'b0);
    expect_out("ch0_m8000", 0, -8000, 0);
    xact(0, 8191, 1'b1, 1'b0, 1'b0);
    expect_out("neg_sat", 0, MINV, 1);
    chk("neg_sat_count", int'(sat_count), 2);

    // Narrow window, clear clamping and inverted window.
    lim_hi = WIDTH'(1000);
    lim_lo = WIDTH'(-1000);
    xact(1, 900, 1'b0, 1'b0, 1'b0);
    expect_out("win_900", 1, 900, 0);
    xact(1, 200, 1'b0, 1'b0, 1'b0);
    expect_out("win_hi", 1, 1000, 1);
    xact(1, 0, 1'b0, 1'b1, 1'b0);
    expect_out("win_clr", 1, 0, 0);
    lim_lo = WIDTH'(10);
    xact(1, 0, 1'b0, 1'b1, 1'b0);
    expect_out("clr_clamp", 1, 10, 1);
    lim_hi = WIDTH'(5);
    lim_lo = WIDTH'(20);
    xact(1, 0, 1'b0, 1'b0, 1'b0);
    expect_out("inverted", 1, 5, 1);
    chk("win_flags", int'(sat_flags), 3);
    chk("win_count", int'(sat_count), 5);
    lim_hi = WIDTH'(MAXV);
    lim_lo = WIDTH'(MINV);
    xact(4, MAXV, 1'b0, 1'b0, 1'b0);
    expect_out("exact_max", 4, MAXV, 0);

    // Backpressure: stall a result for 5 cycles with a request waiting.
    xact(6, 7, 1'b0, 1'b0, 1'b0);
    expect_out("stall_first", 6, 7, 0);
    bus.out_ready = 1'b0;
    bus.in_ch     = CH_W'(6);
    bus.in_delta  = WIDTH'(1);
    bus.in_sub    = 1'b0;
    bus.in_clr    = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", int'(bus.in_ready), 0);
      chk("stall_valid", int'(bus.out_valid), 1);
      chk("stall_value", int'(bus.out_value), 7);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("release_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_out("release", 6, 8, 0);

    // Full-rate streaming on ch 2.
    @(negedge clk);
    bus.in_ch    = CH_W'(2);
    bus.in_delta = WIDTH'(1);
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      expect_out("stream", 2, k, 0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_drain", int'(bus.out_valid), 0);

    // Invalid channel.
    xact(9, 5, 1'b0, 1'b0, 1'b0);
    chk("bad_err",   int'(bus.out_err), 1);
    chk("bad_value", int'(bus.out_value), 0);
    chk("bad_sat",   int'(bus.out_sat), 0);
    chk("bad_ch",    int'(bus.out_ch), 9);
    chk("bad_flags", int'(sat_flags), 3);
    chk("bad_count", int'(sat_count), 5);
    xact(2, 0, 1'b0, 1'b0, 1'b0);
    expect_out("ch2_kept", 2, 4, 0);
    xact(1, 0, 1'b0, 1'b0, 1'b0);
    expect_out("ch1_kept", 1, 5, 0);

    // Flag clear coinciding with a saturating accept on ch 5.
    xact(5, MAXV, 1'b0, 1'b0, 1'b0);
    expect_out("ch5_max", 5, MAXV, 0);
    xact(5, 1, 1'b0, 1'b0, 1'b1);
    expect_out("clr_and_sat", 5, MAXV, 1);
    chk("clr_sat_flags", int'(sat_flags), 32'h20);
    chk("clr_sat_count", int'(sat_count), 1);

    // Reset in the middle of a stream.
    @(negedge clk);
    bus.in_ch    = CH_W'(3);
    bus.in_delta = WIDTH'(1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_flags", int'(sat_flags), 0);
    chk("mid_rst_count", int'(sat_count), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      xact(i, 0, 1'b0, 1'b0, 1'b0);
      expect_out("post_rst", i, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
